// File: rtl/seq101_tx.sv
// Serial frame transmitter: "101" preamble, MSB-first payload, optional even parity,
// then a forced-low gap so a downstream 101 detector settles between frames.
module seq101_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              x_out,
  output logic              done
);

  localparam int unsigned MaxLen = (DATA_W > GAP_LEN) ? ((DATA_W > 3) ? DATA_W : 3)
                                                      : ((GAP_LEN > 3) ? GAP_LEN : 3);
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;

  typedef enum logic [2:0] {StIdle, StPre, StData, StPar, StGap} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic                par_q;
  logic                x_q;
  logic                done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          x_q <= 1'b0;
          if (load) begin
            state_q <= StPre;
            x_q     <= 1'b1;
            cnt_q   <= CntW'(2);
            shreg_q <= data_in;
            par_q   <= ^data_in;
          end
        end
        StPre: begin
          if (cnt_q == '0) begin
            state_q <= StData;
            x_q     <= shreg_q[DATA_W-1];
            shreg_q <= shreg_q << 1;
            cnt_q   <= CntW'(DATA_W - 1);
          end else begin
            // Preamble alternates 1,0,1 starting from the 1 loaded on accept.
            x_q   <= ~x_q;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            if (PARITY_EN != 0) begin
              state_q <= StPar;
              x_q     <= par_q;
            end else begin
              state_q <= StGap;
              x_q     <= 1'b0;
              cnt_q   <= CntW'(GAP_LEN - 1);
            end
          end else begin
            x_q     <= shreg_q[DATA_W-1];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
        StPar: begin
          state_q <= StGap;
          x_q     <= 1'b0;
          cnt_q   <= CntW'(GAP_LEN - 1);
        end
        StGap: begin
          x_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          x_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q != StIdle);
  assign x_out = x_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq101_tx.sv
// Bench for seq101_tx: a frame-level model queues expected per-cycle line/status values on
// each accepted load; a monitor pops and compares them every cycle.
module tb_seq101_tx;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PARITY_EN = 1;
  localparam int unsigned GAP_LEN   = 2;

  typedef struct packed {
    logic x;
    logic ready;
    logic busy;
    logic done;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              busy;
  logic              x_out;
  logic              done;

  exp_t q[$];
  int   rem;
  int   acc;
  bit   check_en;
  int   n_vec;
  int   n_err;
  int   cyc;

  seq101_tx #(
    .DATA_W   (DATA_W),
    .PARITY_EN(PARITY_EN),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .load   (load),
    .ready  (ready),
    .busy   (busy),
    .x_out  (x_out),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Frame as a list of line values; busy for its whole length, then one done cycle.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = int'(DATA_W) - 1; i >= 0; i--) bits.push_back(d[i]);
    if (PARITY_EN != 0) bits.push_back(($countones(d) % 2) == 1);
    for (int i = 0; i < int'(GAP_LEN); i++) bits.push_back(1'b0);
    foreach (bits[i]) begin
      e = '{x: bits[i], ready: 1'b0, busy: 1'b1, done: 1'b0};
      q.push_back(e);
    end
    e = '{x: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b1};
    q.push_back(e);
    rem = bits.size();
  endtask

  // Reference model: decides acceptance from its own notion of remaining busy cycles.
  initial begin
    rem = 0;
    acc = 0;
    check_en = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        rem = 0;
        check_en = 1'b1;
      end else if (rem == 0) begin
        if (load) begin
          push_frame(data_in);
          acc++;
        end
      end else begin
        rem--;
      end
    end
  end

  // Monitor: one comparison per cycle, sampled mid-cycle.
  initial begin
    exp_t want;
    exp_t got;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (check_en) begin
        if (q.size() > 0) want = q.pop_front();
        else want = '{x: 1'b0, ready: 1'b1, busy: 1'b0, done: 1'b0};
        got = '{x: x_out, ready: ready, busy: busy, done: done};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL line_status cycle %0d: got x=%b ready=%b busy=%b done=%b, want x=%b ready=%b busy=%b done=%b",
                   cyc, got.x, got.ready, got.busy, got.done,
                   want.x, want.ready, want.busy, want.done);
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] d);
    @(negedge clk);
    load = 1'b1;
    data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && rem != 0; i++) @(negedge clk);
    if (rem != 0) begin
      n_err++;
      $display("FAIL wait_idle: frame still running after 200 cycles, rem=%0d want 0", rem);
    end
  endtask

  task automatic wait_accept(input int prev);
    for (int i = 0; i < 200 && acc == prev; i++) @(negedge clk);
    if (acc == prev) begin
      n_err++;
      $display("FAIL wait_accept: no accept after 200 cycles, acc=%0d want %0d", acc, prev + 1);
    end
  endtask

  initial begin
    int prev;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    load = 1'b1;
    data_in = 8'h3C;
    // Reset held two cycles with load asserted: no frame may start.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA5);
    wait_idle();
    repeat (2) @(negedge clk);

    send(8'h01);
    wait_idle();
    repeat (2) @(negedge clk);

    // Load while busy is ignored.
    send(8'h00);
    repeat (4) @(negedge clk);
    load = 1'b1;
    data_in = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Back-to-back with load held high.
    prev = acc;
    @(negedge clk);
    load = 1'b1;
    data_in = 8'h0F;
    wait_accept(prev);
    prev = acc;
    data_in = 8'hF0;
    wait_accept(prev);
    load = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Reset at E6 of a frame, fresh load at E8.
    send(8'hA5);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Random traffic: loads at any time, occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 2) != 0);
      data_in = DATA_W'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
